// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 timing constants and helpers shared by the VGA sync
// generator, its sub-modules and the consumers of its interface.
package vga_timing_pkg;

  localparam int DEF_CLK_MHZ       = 50;
  localparam int DEF_PIXEL_MHZ     = 25;
  localparam int DEF_SCREEN_WIDTH  = 640;
  localparam int DEF_SCREEN_HEIGHT = 480;
  localparam int DEF_H_FRONT       = 16;
  localparam int DEF_H_SYNC        = 96;
  localparam int DEF_H_BACK        = 48;
  localparam int DEF_V_FRONT       = 10;
  localparam int DEF_V_SYNC        = 2;
  localparam int DEF_V_BACK        = 33;

  function automatic int line_total(int visible, int front, int sync, int back);
    return visible + front + sync + back;
  endfunction

  function automatic int cnt_width(int total);
    return (total > 1) ? $clog2(total) : 1;
  endfunction

  localparam int H_TOTAL = line_total(DEF_SCREEN_WIDTH, DEF_H_FRONT, DEF_H_SYNC, DEF_H_BACK);
  localparam int V_TOTAL = line_total(DEF_SCREEN_HEIGHT, DEF_V_FRONT, DEF_V_SYNC, DEF_V_BACK);

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic display_on;
  } sync_flags_t;

endpackage

// File: rtl/vga_sync_gen_if.sv
// Video timing bundle: the generator drives it (master), a renderer such as
// game_top reads display_on/x/y straight off it (slave).
interface vga_sync_gen_if #(
  parameter int w_x = 10,
  parameter int w_y = 9
);
  logic           hsync;
  logic           vsync;
  logic           display_on;
  logic [w_x-1:0] x;
  logic [w_y-1:0] y;
  logic           pixel_tick;
  logic           frame_start;

  modport master (
    output hsync, vsync, display_on, x, y, pixel_tick, frame_start
  );

  modport slave (
    input hsync, vsync, display_on, x, y, pixel_tick, frame_start
  );
endinterface

// File: rtl/vga_strobe_div.sv
// Divides the system clock down to a registered one-cycle pixel strobe,
// high in the cycle after the divider reaches its last count.
module vga_strobe_div #(
  parameter int clk_mhz   = 50,
  parameter int pixel_mhz = 25
) (
  input  logic clk,
  input  logic rst,
  output logic strobe
);

  localparam int N = (pixel_mhz > 0) ? clk_mhz / pixel_mhz : 1;

  generate
    if (pixel_mhz < 1 || clk_mhz < pixel_mhz || (clk_mhz % pixel_mhz) != 0) begin : g_bad_ratio
      $error("vga_strobe_div: clk_mhz/pixel_mhz must be an integer >= 1");
    end

    if (N == 1) begin : g_every
      always_ff @(posedge clk or posedge rst) begin
        if (rst) strobe <= 1'b0;
        else     strobe <= 1'b1;
      end
    end else begin : g_count
      localparam int W = $clog2(N);
      localparam logic [W-1:0] DIV_LAST = W'(N - 1);
      logic [W-1:0] div_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          div_reg <= '0;
          strobe  <= 1'b0;
        end else begin
          strobe  <= (div_reg == DIV_LAST);
          div_reg <= (div_reg == DIV_LAST) ? '0 : div_reg + 1'b1;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel/line counters advanced by the pixel strobe,
// with registered sync, blanking, coordinate and frame-start decodes.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int clk_mhz       = DEF_CLK_MHZ,
  parameter int pixel_mhz     = DEF_PIXEL_MHZ,
  parameter int screen_width  = DEF_SCREEN_WIDTH,
  parameter int screen_height = DEF_SCREEN_HEIGHT,
  parameter int h_front       = DEF_H_FRONT,
  parameter int h_sync        = DEF_H_SYNC,
  parameter int h_back        = DEF_H_BACK,
  parameter int v_front       = DEF_V_FRONT,
  parameter int v_sync        = DEF_V_SYNC,
  parameter int v_back        = DEF_V_BACK,
  parameter int w_x           = $clog2(screen_width),
  parameter int w_y           = $clog2(screen_height)
) (
  input  logic           clk,
  input  logic           rst,
  vga_sync_gen_if.master vga
);

  localparam int LINE_TOTAL  = line_total(screen_width, h_front, h_sync, h_back);
  localparam int FRAME_LINES = line_total(screen_height, v_front, v_sync, v_back);
  localparam int HW = cnt_width(LINE_TOTAL);
  localparam int VW = cnt_width(FRAME_LINES);
  localparam logic [HW-1:0] H_LAST = HW'(LINE_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(FRAME_LINES - 1);

  generate
    if (w_x > HW || w_y > VW) begin : g_bad_width
      $error("vga_sync_gen: coordinate width exceeds counter width");
    end
  endgenerate

  logic          pixel_tick;
  logic [HW-1:0] h_cnt_reg, h_cnt_next;
  logic [VW-1:0] v_cnt_reg, v_cnt_next;
  logic          cnt_upd_reg;
  sync_flags_t   flags_reg, flags_next;
  logic [w_x-1:0] x_reg, x_next;
  logic [w_y-1:0] y_reg, y_next;
  logic          frame_start_reg, frame_start_next;

  vga_strobe_div #(
    .clk_mhz   (clk_mhz),
    .pixel_mhz (pixel_mhz)
  ) u_div (
    .clk    (clk),
    .rst    (rst),
    .strobe (pixel_tick)
  );

  always_comb begin
    h_cnt_next = h_cnt_reg;
    v_cnt_next = v_cnt_reg;
    if (pixel_tick) begin
      if (h_cnt_reg == H_LAST) begin
        h_cnt_next = '0;
        v_cnt_next = (v_cnt_reg == V_LAST) ? '0 : v_cnt_reg + 1'b1;
      end else begin
        h_cnt_next = h_cnt_reg + 1'b1;
      end
    end
  end

  // Decodes compare in 32 bits so a sync window ending at TOTAL cannot wrap.
  always_comb begin
    flags_next.display_on = (int'(h_cnt_reg) < screen_width) &&
                            (int'(v_cnt_reg) < screen_height);
    flags_next.hsync = !((int'(h_cnt_reg) >= screen_width + h_front) &&
                         (int'(h_cnt_reg) <  screen_width + h_front + h_sync));
    flags_next.vsync = !((int'(v_cnt_reg) >= screen_height + v_front) &&
                         (int'(v_cnt_reg) <  screen_height + v_front + v_sync));
    frame_start_next = cnt_upd_reg && (h_cnt_reg == '0) && (v_cnt_reg == '0);
  end

  genvar gi;
  generate
    for (gi = 0; gi < w_x; gi++) begin : g_x
      assign x_next[gi] = h_cnt_reg[gi] & flags_next.display_on;
    end
    for (gi = 0; gi < w_y; gi++) begin : g_y
      assign y_next[gi] = v_cnt_reg[gi] & flags_next.display_on;
    end
  endgenerate

  // Reset counts as a counter update, so the first edge after release
  // reports pixel (0,0) together with frame_start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt_reg       <= '0;
      v_cnt_reg       <= '0;
      cnt_upd_reg     <= 1'b1;
      flags_reg       <= '{hsync: 1'b1, vsync: 1'b1, display_on: 1'b0};
      x_reg           <= '0;
      y_reg           <= '0;
      frame_start_reg <= 1'b0;
    end else begin
      h_cnt_reg       <= h_cnt_next;
      v_cnt_reg       <= v_cnt_next;
      cnt_upd_reg     <= pixel_tick;
      flags_reg       <= flags_next;
      x_reg           <= x_next;
      y_reg           <= y_next;
      frame_start_reg <= frame_start_next;
    end
  end

  assign vga.hsync       = flags_reg.hsync;
  assign vga.vsync       = flags_reg.vsync;
  assign vga.display_on  = flags_reg.display_on;
  assign vga.x           = x_reg;
  assign vga.y           = y_reg;
  assign vga.pixel_tick  = pixel_tick;
  assign vga.frame_start = frame_start_reg;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: three configurations checked every cycle against an
// arithmetic pixel-index model, plus fixed vectors and async reset sequences.
module tb_vga_sync_gen;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       de;
    logic [9:0] x;
    logic [8:0] y;
    logic       tick;
    logic       fs;
  } obs_t;

  typedef struct {
    int w, h, hf, hs, hb, vf, vs, vb, n;
  } cfg_t;

  typedef struct {
    int   inst;
    int   k;
    obs_t exp;
  } vec_t;

  localparam obs_t RST_OBS = '{hs: 1'b1, vs: 1'b1, de: 1'b0, x: '0, y: '0, tick: 1'b0, fs: 1'b0};

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   k = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   chk_en = 1'b0;

  cfg_t cfgs[3] = '{'{640, 480, 16, 96, 48, 10, 2, 33, 2},
                    '{640,   8, 16, 96, 48,  2, 2,  3, 1},
                    '{  4,   3,  1,  1,  1,  1, 1,  1, 1}};

  vga_sync_gen_if #(.w_x(10), .w_y(9)) ifa ();
  vga_sync_gen_if #(.w_x(10), .w_y(3)) ifb ();
  vga_sync_gen_if #(.w_x(2),  .w_y(2)) ifc ();

  vga_sync_gen dut_a (.clk(clk), .rst(rst), .vga(ifa));

  vga_sync_gen #(
    .clk_mhz(25), .pixel_mhz(25), .screen_height(8),
    .v_front(2), .v_sync(2), .v_back(3)
  ) dut_b (.clk(clk), .rst(rst), .vga(ifb));

  vga_sync_gen #(
    .clk_mhz(25), .pixel_mhz(25), .screen_width(4), .screen_height(3),
    .h_front(1), .h_sync(1), .h_back(1), .v_front(1), .v_sync(1), .v_back(1)
  ) dut_c (.clk(clk), .rst(rst), .vga(ifc));

  always #5 clk = ~clk;

  // k = rising edges since the last reset release
  always @(posedge clk or posedge rst) begin
    if (rst) k <= 0;
    else     k <= k + 1;
  end

  function automatic obs_t mk(logic hs, logic vs, logic de, logic [9:0] x,
                              logic [8:0] y, logic t, logic f);
    obs_t o;
    o.hs = hs; o.vs = vs; o.de = de; o.x = x; o.y = y; o.tick = t; o.fs = f;
    return o;
  endfunction

  function automatic vec_t mkvec(int inst, int kk, obs_t e);
    vec_t v;
    v.inst = inst; v.k = kk; v.exp = e;
    return v;
  endfunction

  function automatic string iname(int i);
    case (i)
      0:       return "def";
      1:       return "n1";
      default: return "small";
    endcase
  endfunction

  function automatic obs_t sample(int i);
    case (i)
      0: return mk(ifa.hsync, ifa.vsync, ifa.display_on, ifa.x, ifa.y,
                   ifa.pixel_tick, ifa.frame_start);
      1: return mk(ifb.hsync, ifb.vsync, ifb.display_on, ifb.x, 9'(ifb.y),
                   ifb.pixel_tick, ifb.frame_start);
      default: return mk(ifc.hsync, ifc.vsync, ifc.display_on, 10'(ifc.x), 9'(ifc.y),
                         ifc.pixel_tick, ifc.frame_start);
    endcase
  endfunction

  // Pixel index shown after edge kk: ticks land on edges N,2N,..; counters
  // follow one edge later and the decoded outputs one edge after that.
  function automatic obs_t model(cfg_t c, int kk);
    obs_t o;
    int ht, vt, p, pp, h, v;
    if (kk == 0) return RST_OBS;
    ht = c.w + c.hf + c.hs + c.hb;
    vt = c.h + c.vf + c.vs + c.vb;
    p  = (kk < 2) ? 0 : (kk - 2) / c.n;
    pp = (kk < 3) ? 0 : (kk - 3) / c.n;
    h  = p % ht;
    v  = (p / ht) % vt;
    o.de   = (h < c.w) && (v < c.h);
    o.hs   = !((h >= c.w + c.hf) && (h < c.w + c.hf + c.hs));
    o.vs   = !((v >= c.h + c.vf) && (v < c.h + c.vf + c.vs));
    o.x    = o.de ? 10'(h) : 10'd0;
    o.y    = o.de ? 9'(v) : 9'd0;
    o.tick = (kk % c.n) == 0;
    o.fs   = (kk == 1) || ((p != pp) && (h == 0) && (v == 0));
    return o;
  endfunction

  function automatic string fmt(obs_t o);
    return $sformatf("hs=%b vs=%b de=%b x=%0d y=%0d tick=%b fs=%b",
                     o.hs, o.vs, o.de, o.x, o.y, o.tick, o.fs);
  endfunction

  task automatic check(string name, obs_t got, obs_t exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s k=%0d got {%s} need {%s}", name, k, fmt(got), fmt(exp));
    end
  endtask

  task automatic check_val(string name, int got, int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s k=%0d got %0d need %0d", name, k, got, exp);
    end
  endtask

  task automatic wait_k(int target);
    int guard = 0;
    while (k != target && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    if (k != target) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_k timeout got %0d need %0d", k, target);
    end
  endtask

  task automatic check_all_reset(string tag);
    for (int i = 0; i < 3; i++)
      check($sformatf("%s_%s", tag, iname(i)), sample(i), RST_OBS);
  endtask

  always @(negedge clk) begin
    if (chk_en && n_fail < 40) begin
      for (int i = 0; i < 3; i++)
        check($sformatf("model_%s", iname(i)), sample(i), model(cfgs[i], k));
    end
  end

  vec_t vecs[$];

  initial begin
    vecs.push_back(mkvec(0,     1, mk(1, 1, 1,   0, 0, 0, 1)));
    vecs.push_back(mkvec(1,     1, mk(1, 1, 1,   0, 0, 1, 1)));
    vecs.push_back(mkvec(2,     1, mk(1, 1, 1,   0, 0, 1, 1)));
    vecs.push_back(mkvec(0,     2, mk(1, 1, 1,   0, 0, 1, 0)));
    vecs.push_back(mkvec(2,     2, mk(1, 1, 1,   0, 0, 1, 0)));
    vecs.push_back(mkvec(0,     4, mk(1, 1, 1,   1, 0, 1, 0)));
    vecs.push_back(mkvec(2,     7, mk(0, 1, 0,   0, 0, 1, 0)));
    vecs.push_back(mkvec(2,    19, mk(1, 1, 1,   3, 2, 1, 0)));
    vecs.push_back(mkvec(2,    30, mk(1, 0, 0,   0, 0, 1, 0)));
    vecs.push_back(mkvec(2,    43, mk(1, 1, 0,   0, 0, 1, 0)));
    vecs.push_back(mkvec(2,    44, mk(1, 1, 1,   0, 0, 1, 1)));
    vecs.push_back(mkvec(1,   658, mk(0, 1, 0,   0, 0, 1, 0)));
    vecs.push_back(mkvec(0,  1280, mk(1, 1, 1, 639, 0, 1, 0)));
    vecs.push_back(mkvec(0,  1282, mk(1, 1, 0,   0, 0, 1, 0)));
    vecs.push_back(mkvec(0,  1314, mk(0, 1, 0,   0, 0, 1, 0)));
    vecs.push_back(mkvec(0,  1505, mk(0, 1, 0,   0, 0, 0, 0)));
    vecs.push_back(mkvec(0,  1506, mk(1, 1, 0,   0, 0, 1, 0)));
    vecs.push_back(mkvec(0,  1602, mk(1, 1, 1,   0, 1, 1, 0)));
    vecs.push_back(mkvec(1,  6241, mk(1, 1, 1, 639, 7, 1, 0)));
    vecs.push_back(mkvec(1,  8002, mk(1, 0, 0,   0, 0, 1, 0)));
    vecs.push_back(mkvec(1,  9602, mk(1, 1, 0,   0, 0, 1, 0)));
    vecs.push_back(mkvec(1, 12002, mk(1, 1, 1,   0, 0, 1, 1)));

    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check_all_reset("reset_hold");
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      wait_k(vecs[i].k);
      check($sformatf("vec%0d_%s", i, iname(vecs[i].inst)), sample(vecs[i].inst), vecs[i].exp);
      $display("vec %0d %s k=%0d checked", i, iname(vecs[i].inst), vecs[i].k);
    end

    // Mid-frame asynchronous reset on the default configuration.
    @(negedge clk);
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    wait_k(3802);
    check_val("midframe_x", int'(ifa.x), 300);
    check_val("midframe_y", int'(ifa.y), 2);
    #2 rst = 1'b1;
    #1 check_all_reset("async_rst");
    repeat (3) @(posedge clk);
    #1 check_all_reset("rst_held");
    @(negedge clk);
    rst = 1'b0;
    wait_k(1);
    check("post_rst_first", sample(0), mk(1, 1, 1, 0, 0, 0, 1));
    $display("midframe reset at x=300 y=2 checked");

    for (int r = 0; r < 8; r++) begin
      int gap, hold, offs;
      gap  = $urandom_range(1, 2500);
      hold = $urandom_range(1, 4);
      offs = $urandom_range(1, 3);
      repeat (gap) @(negedge clk);
      #(offs) rst = 1'b1;
      #1 check_all_reset($sformatf("rand_rst%0d", r));
      repeat (hold) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      $display("random reset %0d gap=%0d hold=%0d", r, gap, hold);
    end

    repeat (100) @(negedge clk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
